// File: rtl/collision_event_handler.sv
// Collision event handler: per-frame collision latching,
// one-shot kill pulses and the player-life state machine.
module collision_event_handler #(
  parameter int INIT_LIVES    = 3,
  parameter int FREEZE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_game,
  input  logic       collision,
  input  logic       collisionBanana,
  input  logic       drawing_request_spaceship,
  output logic       projectile_kill,
  output logic       banana_kill,
  output logic       ship_hit,
  output logic [2:0] lives,
  output logic       freeze,
  output logic       game_over,
  output logic       playing
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [2:0] INIT_L = 3'(INIT_LIVES);
  localparam logic [7:0] FRZ_L  = 8'(FREEZE_FRAMES);

  logic [1:0] state;
  logic [7:0] frz_cnt;
  logic       proj_l;
  logic       ban_l;
  logic       ship_l;
  logic       active;
  logic       commit;
  logic       hit_now;
  logic       ship_px;

  assign active  = (state == ST_PLAY) || (state == ST_FREEZE);
  assign commit  = active && startOfFrame;
  assign ship_px = collisionBanana && drawing_request_spaceship;
  assign hit_now = commit && (state == ST_PLAY)
                && ship_l && (lives != 3'd0);

  assign freeze    = (state == ST_FREEZE);
  assign game_over = (state == ST_OVER);
  assign playing   = active;

  // Sticky frame latches; restart from this cycle's hits at commit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      proj_l <= 1'b0;
      ban_l  <= 1'b0;
      ship_l <= 1'b0;
    end else if (!active) begin
      proj_l <= 1'b0;
      ban_l  <= 1'b0;
      ship_l <= 1'b0;
    end else if (startOfFrame) begin
      proj_l <= collision;
      ban_l  <= collisionBanana;
      ship_l <= ship_px;
    end else begin
      proj_l <= proj_l | collision;
      ban_l  <= ban_l | collisionBanana;
      ship_l <= ship_l | ship_px;
    end
  end

  // Single-cycle event pulses one cycle after the commit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      projectile_kill <= 1'b0;
      banana_kill     <= 1'b0;
      ship_hit        <= 1'b0;
    end else begin
      projectile_kill <= commit && proj_l;
      banana_kill     <= commit && ban_l;
      ship_hit        <= hit_now;
    end
  end

  // Life state machine: lives, freeze window, game over
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= ST_IDLE;
      lives   <= 3'd0;
      frz_cnt <= 8'd0;
    end else begin
      unique case (state)
        ST_IDLE, ST_OVER: begin
          if (start_game) begin
            state <= ST_PLAY;
            lives <= INIT_L;
          end
        end
        ST_PLAY: begin
          if (hit_now) begin
            lives <= lives - 3'd1;
            if (lives == 3'd1) begin
              state <= ST_OVER;
            end else begin
              state   <= ST_FREEZE;
              frz_cnt <= FRZ_L;
            end
          end
        end
        ST_FREEZE: begin
          if (startOfFrame) begin
            frz_cnt <= frz_cnt - 8'd1;
            if (frz_cnt == 8'd1) begin
              state <= ST_PLAY;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_event_handler.sv
// Scoreboard bench for collision_event_handler with a
// frame-level reference model and randomized stimulus.
module tb_collision_event_handler;

  localparam int INIT = 3;
  localparam int FF   = 30;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       start_game = 1'b0;
  logic       collision = 1'b0;
  logic       collisionBanana = 1'b0;
  logic       drawing_request_spaceship = 1'b0;
  logic       projectile_kill;
  logic       banana_kill;
  logic       ship_hit;
  logic [2:0] lives;
  logic       freeze;
  logic       game_over;
  logic       playing;

  collision_event_handler #(
    .INIT_LIVES(INIT),
    .FREEZE_FRAMES(FF)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .start_game(start_game),
    .collision(collision),
    .collisionBanana(collisionBanana),
    .drawing_request_spaceship(drawing_request_spaceship),
    .projectile_kill(projectile_kill),
    .banana_kill(banana_kill),
    .ship_hit(ship_hit),
    .lives(lives),
    .freeze(freeze),
    .game_over(game_over),
    .playing(playing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pk;
    logic       bk;
    logic       sh;
    logic [2:0] lv;
    logic       fr;
    logic       ov;
    logic       pl;
  } obs_t;

  typedef enum int {M_IDLE, M_PLAY, M_FRZ, M_OVER} mode_t;

  obs_t  expq[$];
  int    checks = 0;
  int    errors = 0;

  mode_t m_mode = M_IDLE;
  int    m_lives = 0;
  int    m_left = 0;
  bit    got_proj = 0;
  bit    got_ban = 0;
  bit    got_ship = 0;

  // Reference: what the game should show one clock later
  task automatic model(input bit rst, input bit s, input bit g,
                       input bit c, input bit b, input bit d);
    obs_t e;
    bit   in_game;
    e = '0;
    if (rst) begin
      m_mode = M_IDLE;
      m_lives = 0;
      m_left = 0;
      got_proj = 0;
      got_ban = 0;
      got_ship = 0;
    end else begin
      in_game = (m_mode == M_PLAY) || (m_mode == M_FRZ);
      if (!in_game) begin
        got_proj = 0;
        got_ban = 0;
        got_ship = 0;
        if (g) begin
          m_mode = M_PLAY;
          m_lives = INIT;
        end
      end else if (s) begin
        e.pk = got_proj;
        e.bk = got_ban;
        if (m_mode == M_PLAY && got_ship && m_lives > 0) begin
          e.sh = 1'b1;
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_mode = M_OVER;
          end else begin
            m_mode = M_FRZ;
            m_left = FF;
          end
        end else if (m_mode == M_FRZ) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_PLAY;
        end
        got_proj = c;
        got_ban = b;
        got_ship = b && d;
      end else begin
        got_proj = got_proj || c;
        got_ban = got_ban || b;
        got_ship = got_ship || (b && d);
      end
    end
    e.lv = 3'(m_lives);
    e.fr = (m_mode == M_FRZ);
    e.ov = (m_mode == M_OVER);
    e.pl = (m_mode == M_PLAY) || (m_mode == M_FRZ);
    expq.push_back(e);
  endtask

  task automatic step(input bit rst, input bit s, input bit g,
                      input bit c, input bit b, input bit d);
    @(negedge clk);
    resetN = !rst;
    startOfFrame = s;
    start_game = g;
    collision = c;
    collisionBanana = b;
    drawing_request_spaceship = d;
    model(rst, s, g, c, b, d);
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic frame(input int len, input int pc, input int pb,
                       input int pd, input int pg);
    for (int i = 0; i < len; i++) begin
      step(0, i == len - 1, rnd(pg), rnd(pc), rnd(pb), rnd(pd));
    end
  endtask

  // Monitor: compare every registered output cycle
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = '{projectile_kill, banana_kill, ship_hit, lives,
              freeze, game_over, playing};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got pk=%b bk=%b sh=%b lv=%0d fr=%b ov=%b pl=%b want pk=%b bk=%b sh=%b lv=%0d fr=%b ov=%b pl=%b",
                   $time, a.pk, a.bk, a.sh, a.lv, a.fr, a.ov, a.pl,
                   e.pk, e.bk, e.sh, e.lv, e.fr, e.ov, e.pl);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step(1, 0, 0, 0, 0, 0);
    repeat (2) frame(5, 50, 50, 50, 0);
    step(0, 0, 1, 0, 0, 0);
    frame(6, 0, 0, 0, 0);
    // long projectile contact inside one frame
    for (int i = 0; i < 60; i++) begin
      step(0, i == 59, 0, (i >= 5 && i < 55), 0, 0);
    end
    frame(5, 0, 0, 0, 0);
    // banana on the ship, then freeze window with more hits
    for (int i = 0; i < 20; i++) begin
      step(0, i == 19, 0, 0, (i < 10), (i < 10));
    end
    repeat (FF + 4) frame(5, 20, 40, 60, 0);
    // drive toward game over
    n = 0;
    while (m_mode != M_OVER && n < 400) begin
      frame($urandom_range(3, 6), 20, 50, 80, 0);
      n++;
    end
    repeat (3) frame(5, 80, 80, 80, 0);
    step(0, 0, 1, 0, 0, 0);
    // collision only during the commit cycle
    frame(5, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, i == 4, 0, i == 4, 0, 0);
    end
    frame(5, 0, 0, 0, 0);
    frame(5, 0, 0, 0, 0);
    // reset in freeze with latches set
    for (int i = 0; i < 5; i++) begin
      step(0, i == 4, 0, 0, 1, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1, 1);
    end
    repeat (2) step(1, 0, 0, 1, 1, 1);
    repeat (3) frame(4, 60, 60, 60, 0);
    // start_game together with startOfFrame
    step(0, 1, 1, 1, 1, 1);
    repeat (3) frame(4, 30, 30, 30, 0);
    // random soak
    for (int f = 0; f < 250; f++) begin
      if (rnd(2)) step(1, 0, 0, 0, 0, 0);
      frame($urandom_range(2, 8), 20, 25, 40, 3);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_event_handler.md
Name: collision_event_handler

Overview:
- Consumer end of the per-pixel collision interface produced by the game controller.
- Accumulates collision strobes over a frame and commits them once per frame at startOfFrame as single-cycle event pulses for the projectile and banana objects.
- Runs the player-life state machine: lives count, post-hit freeze window, game over.
- Sits between the game controller and the object movement/score blocks.

Parameters:
- INIT_LIVES, 3, lives loaded on game start (1..7).
- FREEZE_FRAMES, 30, frames the ship is frozen/invulnerable after a hit (1..255).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_game  in  1  level/pulse request to start a game
- collision  in  1  projectile touching border or shield (pixel-level, many cycles per frame)
- collisionBanana  in  1  banana touching border, shield or ship
- drawing_request_spaceship  in  1  ship pixel active (qualifies a banana hit on the ship)
- projectile_kill  out  1  one-cycle pulse: remove projectile
- banana_kill  out  1  one-cycle pulse: remove banana
- ship_hit  out  1  one-cycle pulse: ship lost a life
- lives  out  3  remaining lives
- freeze  out  1  high while in FREEZE state
- game_over  out  1  high in OVER state
- playing  out  1  high in PLAY or FREEZE

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- Reset values:
  - all pulses 0; lives=0; freeze=0; game_over=0; playing=0.
  - state IDLE; all latches 0; freeze counter 0.
- Frame latches (sticky), in PLAY/FREEZE only:
  - proj_l set on collision.
  - ban_l set on collisionBanana.
  - ship_l set on collisionBanana && drawing_request_spaceship.
  - In IDLE/OVER the latches are held at 0.
- Commit at startOfFrame (cycle N):
  - Latches are sampled, then cleared, in the same cycle.
  - A collision in cycle N itself goes to the next frame's latch, not the cleared one.
  - Outputs in cycle N+1: projectile_kill=proj_l, banana_kill=ban_l, each high exactly one cycle. At most one pulse of each per frame, regardless of the number of colliding pixels.
- FSM:
  - IDLE: playing=0. start_game -> PLAY, lives<=INIT_LIVES.
  - PLAY: at commit with ship_l=1:
    - ship_hit pulse at N+1 and lives<=lives-1.
    - If new lives==0 -> OVER, else -> FREEZE with counter<=FREEZE_FRAMES.
  - FREEZE: freeze=1.
    - ship_l is ignored, so no ship_hit and no decrement.
    - banana_kill and projectile_kill still commit normally.
    - Counter decrements at each startOfFrame; when it is 1 at a startOfFrame -> PLAY at the next cycle.
  - OVER: game_over=1, lives=0, no pulses. start_game -> PLAY, lives<=INIT_LIVES, latches cleared.
- Simultaneous events:
  - start_game and startOfFrame in the same cycle: start_game wins; no commit that frame.
  - In OVER, pending latches are discarded.
- Lives never underflow: decrement only when lives>0.
- Reset mid-frame or mid-freeze returns to IDLE immediately; no pulses are emitted on reset release.
- Latency: event visible at startOfFrame+1 cycle; FSM outputs are registered.

Test Plan:
1. Reset, then start_game; hold collision for 50 cycles in one frame -> exactly one projectile_kill pulse, one cycle after the next startOfFrame; lives=3.
2. PLAY, collisionBanana && drawing_request_spaceship for 10 cycles -> at next startOfFrame+1: banana_kill=1, ship_hit=1, lives=2, freeze=1 for exactly 30 frames, then PLAY.
3. Ship hit during FREEZE -> banana_kill pulses, no ship_hit, lives unchanged.
4. Three ship hits separated by the freeze window -> lives 3→2→1→0, game_over=1, playing=0. Further collisions produce no pulses. start_game -> lives=3, PLAY.
5. collision asserted only in the startOfFrame cycle -> no pulse at N+1; projectile_kill at the following frame commit.
6. Assert resetN low during FREEZE with latches set -> all outputs 0 and state IDLE; no pulse after release.
